// File: rtl/dmem_responder.sv
// dmem_responder -- responder end of the core's data-memory port.
//
// Word-addressed read/write requests arrive on the same signal names the core
// already drives. A ready/valid handshake with a programmable read latency is
// layered on top so a pipelined core can stall on memory. The top four word
// addresses are memory-mapped registers.
//
// Handshake: a request is accepted on the rising CLK edge where
// (MemRead | MemWrite) & mem_ready. Requests seen while mem_ready=0 are dropped
// (no queuing). Writes commit at the accept edge and produce no response.
// A read raises rd_valid for exactly one cycle, READ_LAT cycles after its
// accept edge; data_DMEM holds that word until the next read completes. A new
// request may be accepted in the same cycle rd_valid is high.
// MemRead & MemWrite together is a write only.
//
// Address map (word addresses):
//   0x000..0x3FB  1020 x 32 RAM (not cleared by reset)
//   0x3FC         free-running 32-bit cycle counter, read-only
//   0x3FD         GPIO output register, GPIO_W bits, read zero-extended
//   0x3FE..0x3FF  unmapped: reads return 0, writes ignored
//
// Parameters:
//   READ_LAT  read latency in cycles, legal range 1..4
//   GPIO_W    width of the GPIO register (1..32)
//
// Ports:
//   CLK              clock, all state on rising edge
//   RST              asynchronous, active-high reset
//   MemRead          read request
//   MemWrite         write request
//   address_DMEM     word address
//   write_data_DMEM  write data
//   mem_ready        responder can accept a request this cycle
//   rd_valid         one-cycle pulse: data_DMEM holds a completed read
//   data_DMEM        read data
//   gpio_out         GPIO register contents
//   err              error pulse (DMEM_ERR_EN builds only, else tied 0)
//
// Build option: define DMEM_ERR_EN to enable the err pulse. It fires on the
// cycle after the accept edge of a request with MemRead&MemWrite both set, a
// request to 0x3FE/0x3FF, or a write to 0x3FC.

module dmem_responder #(
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned GPIO_W   = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [9:0]        address_DMEM,
   input  logic [31:0]       write_data_DMEM,
   output logic              mem_ready,
   output logic              rd_valid,
   output logic [31:0]       data_DMEM,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              err
);

   localparam int unsigned RAM_WORDS = 1020;
   localparam logic [9:0]  ADDR_CNT  = 10'h3FC;
   localparam logic [9:0]  ADDR_GPIO = 10'h3FD;
   // WAIT counts down from READ_LAT-2 to 0; unused when READ_LAT=1.
   localparam logic [1:0]  WAIT_LOAD = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t      state;
   logic [1:0]  wait_cnt;
   logic [31:0] ram [0:RAM_WORDS-1];
   logic [31:0] cyc_cnt;
   logic [31:0] cap_q;
   logic [31:0] rd_word;
   logic [31:0] gpio_ext;
   logic        req;
   logic        accept;
   logic        wr_acc;
   logic        rd_acc;
   logic        is_ram;

   assign req    = MemRead | MemWrite;
   assign accept = req & mem_ready;
   assign wr_acc = accept & MemWrite;
   // A simultaneous read+write is a write only, so it never starts a read.
   assign rd_acc = accept & MemRead & ~MemWrite;
   assign is_ram = (address_DMEM < 10'(RAM_WORDS));

   always_comb begin
      gpio_ext               = '0;
      gpio_ext[GPIO_W-1:0]   = gpio_out;
   end

   // Value a read accepted this cycle returns. Sampled at the accept edge, so
   // the counter reads its pre-increment value and later writes do not leak
   // into an in-flight read.
   always_comb begin
      rd_word = '0;
      if (is_ram) begin
         rd_word = ram[address_DMEM];
      end else if (address_DMEM == ADDR_CNT) begin
         rd_word = cyc_cnt;
      end else if (address_DMEM == ADDR_GPIO) begin
         rd_word = gpio_ext;
      end
   end

   // RAM array has no reset so its contents survive RST.
   always_ff @(posedge CLK) begin
      if (wr_acc && is_ram) begin
         ram[address_DMEM] <= write_data_DMEM;
      end
   end

   // Counter, GPIO register and the read FSM with its registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         wait_cnt  <= 2'd0;
         mem_ready <= 1'b1;
         rd_valid  <= 1'b0;
         data_DMEM <= '0;
         cap_q     <= '0;
         gpio_out  <= '0;
         cyc_cnt   <= '0;
      end else begin
         cyc_cnt  <= cyc_cnt + 32'd1;
         rd_valid <= 1'b0;

         if (wr_acc && (address_DMEM == ADDR_GPIO)) begin
            gpio_out <= write_data_DMEM[GPIO_W-1:0];
         end

         case (state)
            ST_IDLE: begin
               if (rd_acc) begin
                  if (READ_LAT == 1) begin
                     // Single-cycle read: result lands directly, stay ready.
                     rd_valid  <= 1'b1;
                     data_DMEM <= rd_word;
                  end else begin
                     cap_q     <= rd_word;
                     wait_cnt  <= WAIT_LOAD;
                     mem_ready <= 1'b0;
                     state     <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt != 2'd0) begin
                  wait_cnt <= wait_cnt - 2'd1;
               end else begin
                  // Completion: valid and ready rise together, so the core
                  // may issue its next request in the rd_valid cycle.
                  state     <= ST_IDLE;
                  mem_ready <= 1'b1;
                  rd_valid  <= 1'b1;
                  data_DMEM <= cap_q;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef DMEM_ERR_EN
   logic err_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept & ((MemRead & MemWrite) |
                            (address_DMEM >= 10'h3FE) |
                            (MemWrite & (address_DMEM == ADDR_CNT)));
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (READ_LAT 1, 3, 4) share one
// request bus. A transaction-level model predicts every output each cycle;
// directed steps add hand-computed literal expectations.

module tb_dmem_responder;

`ifdef DMEM_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif
   localparam int LAT [3] = '{1, 3, 4};

   // ---------------- clock / reset / bus ----------------
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [9:0]  addr = '0;
   logic [31:0] wdata = '0;

   logic        mr [3];
   logic        rv [3];
   logic [31:0] dd [3];
   logic [7:0]  go [3];
   logic        er [3];

   always #5 CLK = ~CLK;

   dmem_responder #(.READ_LAT(1), .GPIO_W(8)) u_l1 (
      .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
      .address_DMEM(addr), .write_data_DMEM(wdata),
      .mem_ready(mr[0]), .rd_valid(rv[0]), .data_DMEM(dd[0]),
      .gpio_out(go[0]), .err(er[0]));

   dmem_responder #(.READ_LAT(3), .GPIO_W(8)) u_l3 (
      .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
      .address_DMEM(addr), .write_data_DMEM(wdata),
      .mem_ready(mr[1]), .rd_valid(rv[1]), .data_DMEM(dd[1]),
      .gpio_out(go[1]), .err(er[1]));

   dmem_responder #(.READ_LAT(4), .GPIO_W(8)) u_l4 (
      .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
      .address_DMEM(addr), .write_data_DMEM(wdata),
      .mem_ready(mr[2]), .rd_valid(rv[2]), .data_DMEM(dd[2]),
      .gpio_out(go[2]), .err(er[2]));

   // ---------------- scoreboard counters ----------------
   int n_pass  = 0;
   int n_total = 0;
   logic chk_en = 1'b0;
   logic cnt_jump = 1'b0;

   task automatic check(input string name, input int k,
                        input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s[lat%0d] at %0t: got %h expected %h",
                  name, LAT[k], $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Each instance: memory image, counter = edges since reset, and a countdown
   // of cycles until the outstanding read's data appears.
   logic [31:0] m_ram  [3][1024];
   logic [31:0] m_cnt  [3];
   logic [7:0]  m_gpio [3];
   int          m_rem  [3];
   logic [31:0] m_cap  [3];
   logic        e_ready [3];
   logic        e_valid [3];
   logic        e_err   [3];
   logic [31:0] e_data  [3];

   function automatic logic [31:0] model_read(input int k, input logic [9:0] a);
      if (a < 10'h3FC) return m_ram[k][a];
      if (a == 10'h3FC) return m_cnt[k];
      if (a == 10'h3FD) return {24'h0, m_gpio[k]};
      return 32'h0;
   endfunction

   always @(posedge CLK or posedge RST) begin
      for (int k = 0; k < 3; k++) begin
         if (RST) begin
            m_cnt[k]   = '0;
            m_gpio[k]  = '0;
            m_rem[k]   = 0;
            m_cap[k]   = '0;
            e_valid[k] = 1'b0;
            e_err[k]   = 1'b0;
            e_data[k]  = '0;
         end else begin
            if (k == 0 && cnt_jump) m_cnt[0] = 32'hFFFF_FFFF;
            e_valid[k] = 1'b0;
            e_err[k]   = 1'b0;
            if (m_rem[k] > 0) begin
               m_rem[k]--;
               if (m_rem[k] == 0) begin
                  e_valid[k] = 1'b1;
                  e_data[k]  = m_cap[k];
               end
            end else if (MemRead || MemWrite) begin
               e_err[k] = (MemRead && MemWrite) || (addr >= 10'h3FE) ||
                          (MemWrite && addr == 10'h3FC);
               if (MemWrite) begin
                  if (addr < 10'h3FC) m_ram[k][addr] = wdata;
                  else if (addr == 10'h3FD) m_gpio[k] = wdata[7:0];
               end else if (LAT[k] == 1) begin
                  e_valid[k] = 1'b1;
                  e_data[k]  = model_read(k, addr);
               end else begin
                  m_cap[k] = model_read(k, addr);
                  m_rem[k] = LAT[k] - 1;
               end
            end
            m_cnt[k] = m_cnt[k] + 32'd1;
         end
         e_ready[k] = (m_rem[k] == 0);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            check("mem_ready", k, 32'(mr[k]), 32'(e_ready[k]));
            check("rd_valid",  k, 32'(rv[k]), 32'(e_valid[k]));
            check("data_DMEM", k, dd[k], e_data[k]);
            check("gpio_out",  k, 32'(go[k]), 32'(m_gpio[k]));
            check("err",       k, 32'(er[k]), 32'(ERR_ON & e_err[k]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic do_write(input logic [9:0] a, input logic [31:0] d);
      MemRead = 1'b0; MemWrite = 1'b1; addr = a; wdata = d;
      @(posedge CLK);
      @(negedge CLK);
      MemWrite = 1'b0;
   endtask

   // Returns the READ_LAT=1 instance's data in the cycle after acceptance.
   task automatic do_read(input logic [9:0] a, output logic [31:0] d);
      MemRead = 1'b1; MemWrite = 1'b0; addr = a;
      @(posedge CLK);
      @(negedge CLK);
      MemRead = 1'b0;
      check("l1_rd_valid_next", 0, 32'(rv[0]), 32'd1);
      d = dd[0];
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < 3; k++) begin
         check({tag, "_ready"}, k, 32'(mr[k]), 32'd1);
         check({tag, "_valid"}, k, 32'(rv[k]), 32'd0);
         check({tag, "_data"},  k, dd[k], 32'd0);
         check({tag, "_gpio"},  k, 32'(go[k]), 32'd0);
         check({tag, "_err"},   k, 32'(er[k]), 32'd0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v1;
      logic [31:0] v2;
      int          pulses;

      #1 RST = 1'b1;
      #1 check_reset_outputs("reset");
      chk_en = 1'b1;
      idle(2);
      RST = 1'b0;

      // Give every RAM word a known value.
      for (int a = 0; a < 1020; a++) do_write(10'(a), $urandom);

      // Write then read at READ_LAT=1.
      do_write(10'h010, 32'h1234_5678);
      do_read(10'h010, v1);
      check("l1_read_data", 0, v1, 32'h1234_5678);
      check("l1_ready_kept", 0, 32'(mr[0]), 32'd1);
      idle(5);
      check("l3_read_data", 1, dd[1], 32'h1234_5678);
      check("l4_read_data", 2, dd[2], 32'h1234_5678);

      // READ_LAT=3 timing, new request accepted in the rd_valid cycle.
      MemRead = 1'b1; addr = 10'h010;
      @(posedge CLK);
      @(negedge CLK);
      MemRead = 1'b0;
      check("l3_wait1_ready", 1, 32'(mr[1]), 32'd0);
      check("l3_wait1_valid", 1, 32'(rv[1]), 32'd0);
      @(negedge CLK);
      check("l3_wait2_ready", 1, 32'(mr[1]), 32'd0);
      @(negedge CLK);
      check("l3_done_valid", 1, 32'(rv[1]), 32'd1);
      check("l3_done_ready", 1, 32'(mr[1]), 32'd1);
      check("l3_done_data",  1, dd[1], 32'h1234_5678);
      MemRead = 1'b1; addr = 10'h011;
      @(negedge CLK);
      MemRead = 1'b0;
      check("l3_accept_in_valid", 1, 32'(mr[1]), 32'd0);
      idle(6);

      // GPIO write/read.
      do_write(10'h3FD, 32'hFFFF_FFAB);
      for (int k = 0; k < 3; k++) check("gpio_write", k, 32'(go[k]), 32'h0000_00AB);
      do_read(10'h3FD, v1);
      check("gpio_read", 0, v1, 32'h0000_00AB);
      idle(6);

      // Counter reads 5 cycles apart.
      do_read(10'h3FC, v1);
      idle(4);
      do_read(10'h3FC, v2);
      check("cnt_delta", 0, v2 - v1, 32'd5);
      idle(6);

      // Counter wrap on the READ_LAT=1 instance.
      force u_l1.cyc_cnt = 32'hFFFF_FFFF;
      cnt_jump = 1'b1;
      #1 release u_l1.cyc_cnt;
      do_read(10'h3FC, v1);
      cnt_jump = 1'b0;
      check("cnt_max", 0, v1, 32'hFFFF_FFFF);
      do_read(10'h3FC, v2);
      check("cnt_wrap", 0, v2, 32'h0000_0000);
      idle(6);

      // Reset during a READ_LAT=4 read.
      MemRead = 1'b1; addr = 10'h010;
      @(posedge CLK);
      @(negedge CLK);
      MemRead = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #2 RST = 1'b1;
      #1 check_reset_outputs("midread_reset");
      idle(2);
      RST = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(negedge CLK);
         if (rv[2]) pulses++;
      end
      check("l4_no_valid_after_reset", 2, 32'(pulses), 32'd0);
      do_read(10'h010, v1);
      check("ram_kept_l1", 0, v1, 32'h1234_5678);
      idle(5);
      check("ram_kept_l4", 2, dd[2], 32'h1234_5678);

      // Read+write together, and a write to an unmapped slot.
      MemRead = 1'b1; MemWrite = 1'b1; addr = 10'h020; wdata = 32'h5;
      @(posedge CLK);
      @(negedge CLK);
      MemRead = 1'b0; MemWrite = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("rw_err", k, 32'(er[k]), 32'(ERR_ON));
         check("rw_no_valid", k, 32'(rv[k]), 32'd0);
      end
      @(negedge CLK);
      check("rw_err_one_cycle", 0, 32'(er[0]), 32'd0);
      do_read(10'h020, v1);
      check("rw_wrote", 0, v1, 32'h0000_0005);
      idle(5);
      do_write(10'h3FE, 32'h77);
      check("unmapped_wr_err", 0, 32'(er[0]), 32'(ERR_ON));
      do_read(10'h3FE, v1);
      check("unmapped_rd", 0, v1, 32'h0);
      idle(6);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 9);
         MemRead  = (r <= 3) || (r == 7);
         MemWrite = (r >= 4) && (r <= 7);
         if ($urandom_range(0, 3) == 0) addr = 10'h3FC + 10'($urandom_range(0, 3));
         else addr = 10'($urandom_range(0, 1023));
         wdata = $urandom;
         @(negedge CLK);
      end
      MemRead = 1'b0; MemWrite = 1'b0;
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory port.
- Accepts word-addressed read/write requests, using the same signal names the core drives (address_DMEM, write_data_DMEM, MemRead, MemWrite), and returns data_DMEM.
- Adds a ready/valid handshake with programmable read latency, so later pipelined cores can stall on memory.
- Top four word addresses are memory-mapped: free-running cycle counter, GPIO output register and two unmapped slots.

Parameters:
- READ_LAT, 1, read latency in cycles from accept edge to rd_valid; legal range 1..4.
- GPIO_W, 8, width of the GPIO output register.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- MemRead  in  1  read request
- MemWrite  in  1  write request
- address_DMEM  in  10  word address
- write_data_DMEM  in  32  write data
- mem_ready  out  1  responder can accept a request this cycle
- rd_valid  out  1  one-cycle pulse: data_DMEM holds a completed read
- data_DMEM  out  32  read data, held until the next read completes
- gpio_out  out  GPIO_W  GPIO register contents
- err  out  1  error pulse (see Optional Feature)

Behaviour:
- Reset (async, asserted): all registers clear immediately; RAM contents are not cleared.
  - mem_ready=1, rd_valid=0, data_DMEM=0, gpio_out=0, err=0, cycle counter=0, FSM=IDLE.
- Accept: a request is accepted on the rising edge where (MemRead|MemWrite)=1 and mem_ready=1. Requests while mem_ready=0 are ignored; there is no queuing.
- MemRead=1 and MemWrite=1 together: treated as a write only; no read response is produced.
- Address map:
  - 0x000..0x3FB: 1020x32 RAM.
  - 0x3FC: cycle counter. Read-only; writes are ignored.
  - 0x3FD: GPIO register. Read/write; reads return the value zero-extended to 32 bits, writes take bits [GPIO_W-1:0].
  - 0x3FE..0x3FF: unmapped. Reads return 0; writes are ignored.
- Writes:
  - Committed at the accept edge; no response.
  - mem_ready stays 1, so throughput is one write per cycle.
- Cycle counter:
  - 32-bit, increments every cycle after reset deassertion and wraps 0xFFFFFFFF->0.
  - A read of 0x3FC returns the value sampled at the accept edge.
- Read FSM, states IDLE and WAIT, with a 2-bit down-counter:
  - IDLE, read accepted:
    - READ_LAT=1: stay in IDLE. In the next cycle rd_valid=1 and data_DMEM is valid, mem_ready stays 1, and back-to-back reads run at one per cycle.
    - READ_LAT>1: go to WAIT, load counter with READ_LAT-2, mem_ready=0.
  - WAIT:
    - Counter>0: decrement, mem_ready stays 0.
    - Counter=0: return to IDLE. In the following cycle rd_valid=1, data_DMEM is valid and mem_ready=1.
  - Result: rd_valid is asserted exactly READ_LAT cycles after the accept edge, and a new request can be accepted in the same cycle that rd_valid is high.
- RAM read data is captured at the accept edge, so a write accepted in the rd_valid cycle does not alter the data already returned.
- data_DMEM updates only when a read completes; writes never change it.
- Reset mid-read: the pending read is dropped, no rd_valid is produced, and the FSM returns to IDLE.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: err pulses high for one cycle, on the cycle after the accept edge, when either condition holds:
  - an accepted request has MemRead=1 and MemWrite=1 simultaneously, or
  - an accepted request targets 0x3FE/0x3FF, or is a write to 0x3FC.
  - All other behaviour is unchanged.
- Undefined: err is tied to 0 and the error-detection logic is absent.

Test Plan:
- Reset, then write 0x12345678 to 0x010, then read 0x010 with READ_LAT=1 -> rd_valid one cycle after accept, data_DMEM=0x12345678, mem_ready never drops.
- READ_LAT=3, read 0x010 -> mem_ready=0 for 2 cycles, rd_valid on the 3rd cycle after accept, and a request presented in that cycle is accepted.
- Write 0xFFFFFFAB to 0x3FD (GPIO_W=8) -> gpio_out=0xAB next cycle; read 0x3FD -> data_DMEM=0x000000AB.
- Read 0x3FC twice, 5 cycles apart, READ_LAT=1 -> returned values differ by exactly 5; force the counter to 0xFFFFFFFF -> the next value read is 0x00000000.
- READ_LAT=4: accept read, assert RST two cycles later -> outputs at reset values immediately, no rd_valid afterwards, previously written RAM data still readable.
- With DMEM_ERR_EN: MemRead=MemWrite=1 to 0x020 with data 0x5 -> err pulses once, no rd_valid, later read of 0x020 returns 0x5. Write to 0x3FE -> err pulses once, a read returns 0.
